bus_source_arbiter_encoder: RTL and testbench

// Inverse of the bus-load decoder: collects per-source bus requests from registers/memory and

---
 rtl/bus_source_arbiter_encoder.sv | 130 +++++++++++++
 tb/tb_bus_source_arbiter_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_source_arbiter_encoder.sv
// Round-robin bus source arbiter that encodes the winning source into the
// binary select code for the common-bus multiplexer. A grant is held until
// the owner signals done, drops its request, or exceeds MAX_HOLD cycles.
// Every release is followed by one idle cycle, so ownership never changes
// hands within a single cycle.
//
// Handshake: req[i] is a level held by source i for as long as it wants the
// bus. bus_valid/grant/sel describe the current owner. done is a one-cycle
// strobe from the owner and is only honoured while a grant is active.
module bus_source_arbiter_encoder #(
    parameter int NUM_SRC  = 16,
    parameter int SEL_W    = 4,
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] grant,
    output logic               bus_valid,
    output logic               timeout
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic               bus_valid_q, bus_valid_d;
    logic               timeout_q, timeout_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [SEL_W-1:0]   winner;
    logic               found;
    logic [SEL_W-1:0]   scan_idx;
    logic               hold_hit;
    logic               owner_req;

    // Round-robin scan: first requesting source at or after ptr, wrapping mod NUM_SRC.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            scan_idx = ptr_q + SEL_W'(i);
            if (!found && req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign owner_req = req[sel_q];

    // Next-state and registered-output logic; release priority is done, abort, timeout.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        bus_valid_d = bus_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        case (state_q)
            IDLE: begin
                grant_d     = '0;
                bus_valid_d = 1'b0;
                if (found) begin
                    state_d     = OWN;
                    sel_d       = winner;
                    grant_d     = NUM_SRC'(1) << winner;
                    bus_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            OWN: begin
                if (done || !owner_req || hold_hit) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    bus_valid_d = 1'b0;
                    ptr_d       = sel_q + 1'b1;
                    timeout_d   = !done && owner_req && hold_hit;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            bus_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            bus_valid_q <= bus_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign bus_valid = bus_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_source_arbiter_encoder.sv
// Bench for bus_source_arbiter_encoder: directed scenarios plus random
// traffic, checked cycle by cycle against a behavioural reference model.
module tb_bus_source_arbiter_encoder;
    localparam int NUM_SRC  = 16;
    localparam int SEL_W    = 4;
    localparam int HOLD_W   = 8;
    localparam int MAX_HOLD = 4;
    localparam int W        = SEL_W + NUM_SRC + 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_SRC-1:0] req = '0;
    logic               done = 1'b0;
    logic [SEL_W-1:0]   sel;
    logic [NUM_SRC-1:0] grant;
    logic               bus_valid;
    logic               timeout;

    bus_source_arbiter_encoder #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W),
        .HOLD_W  (HOLD_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .sel      (sel),
        .grant    (grant),
        .bus_valid(bus_valid),
        .timeout  (timeout)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           vectors = 0;
    int           miscompares = 0;

    // Reference model: who owns the bus, where the round-robin scan starts,
    // how long the owner has held it, and whether a timeout was just flagged.
    bit m_own;
    int m_sel;
    int m_ptr;
    int m_hold;
    bit m_to;

    task automatic model_reset();
        m_own = 0; m_sel = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [NUM_SRC-1:0] r, input logic d);
        bit stay;
        bit hit;
        if (!m_own) begin
            m_to = 0;
            for (int k = 0; k < NUM_SRC; k++) begin
                int idx;
                idx = (m_ptr + k) % NUM_SRC;
                if (r[idx]) begin
                    m_sel = idx; m_own = 1; m_hold = 0;
                    break;
                end
            end
        end else begin
            stay = r[m_sel];
            hit  = (MAX_HOLD != 0) && (m_hold == MAX_HOLD - 1);
            if (d || !stay || hit) begin
                m_to  = !d && stay && hit;
                m_own = 0;
                m_ptr = (m_sel + 1) % NUM_SRC;
            end else begin
                m_to   = 0;
                m_hold = (m_hold < (1 << HOLD_W) - 1) ? m_hold + 1 : m_hold;
            end
        end
    endtask

    function automatic logic [W-1:0] model_outputs();
        logic [NUM_SRC-1:0] g;
        logic [SEL_W-1:0]   s;
        g = '0;
        if (m_own) g[m_sel] = 1'b1;
        s = SEL_W'(m_sel);
        return {s, g, m_own, m_to};
    endfunction

    // Driver: apply one cycle of inputs, predict the outputs after the next edge.
    task automatic step(input logic [NUM_SRC-1:0] r, input logic d);
        req  = r;
        done = d;
        model_step(r, d);
        exp_q.push_back(model_outputs());
        due_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare outputs against the expectation due this cycle.
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0 && due_q[0] <= cyc) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            int           due;
            e   = exp_q.pop_front();
            due = due_q.pop_front();
            a   = {sel, grant, bus_valid, timeout};
            vectors++;
            if (due != cyc || a !== e) begin
                miscompares++;
                $display("FAIL outputs cyc=%0d: got sel=%0d grant=%h valid=%b timeout=%b, want sel=%0d grant=%h valid=%b timeout=%b",
                         cyc, a[W-1 -: SEL_W], a[NUM_SRC+1:2], a[1], a[0],
                         e[W-1 -: SEL_W], e[NUM_SRC+1:2], e[1], e[0]);
            end
            vectors++;
            if (bus_valid ? (grant !== (NUM_SRC'(1) << sel)) : (grant !== '0)) begin
                miscompares++;
                $display("FAIL onehot cyc=%0d: got grant=%h valid=%b sel=%0d, want grant==1<<sel iff valid",
                         cyc, grant, bus_valid, sel);
            end
        end
    end

    task automatic check_zero(input string name);
        vectors++;
        if ({sel, grant, bus_valid, timeout} !== '0) begin
            miscompares++;
            $display("FAIL %s: got sel=%0d grant=%h valid=%b timeout=%b, want all zero",
                     name, sel, grant, bus_valid, timeout);
        end
    endtask

    // Stimulus sequence
    initial begin
        logic [NUM_SRC-1:0] rr;
        model_reset();
        #12;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // idle with no requests
        step('0, 1'b0);
        step('0, 1'b1);

        // two requesters: 0 first, then 7 after the pointer moves past 0
        step(16'h0081, 1'b0);
        step(16'h0081, 1'b0);
        step(16'h0081, 1'b1);
        step(16'h0081, 1'b0);
        step(16'h0081, 1'b1);
        step('0, 1'b0);

        // wrap: grant 15, release, pointer wraps to 0
        step(16'h8000, 1'b0);
        step(16'h8000, 1'b1);
        step(16'h8001, 1'b0);
        step(16'h8001, 1'b1);
        step('0, 1'b0);

        // abort: owner 3 drops its request; pointer must move to 4
        step(16'h0008, 1'b0);
        step(16'h0008, 1'b0);
        step(16'h0000, 1'b0);
        step(16'h0018, 1'b0);
        step(16'h0018, 1'b1);
        step('0, 1'b0);

        // timeout: source 5 holds without done
        repeat (8) step(16'h0020, 1'b0);
        step('0, 1'b0);
        step('0, 1'b0);

        // done coinciding with the timeout cycle suppresses the pulse
        step(16'h0020, 1'b0);
        repeat (3) step(16'h0020, 1'b0);
        step(16'h0020, 1'b1);
        step('0, 1'b0);

        // fairness with every source requesting
        for (int i = 0; i < 40; i++) step(16'hFFFF, (i % 2) == 1);
        step('0, 1'b0);

        // reset asserted while a grant is active
        step(16'h0200, 1'b0);
        step(16'h0200, 1'b0);
        #5;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_mid_own");
        exp_q.delete();
        due_q.delete();
        model_reset();
        req = '0;
        done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step('0, 1'b0);

        // random traffic; requests change occasionally so holds reach the timeout
        rr = '0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 3) == 0) rr = '0;
                else rr = NUM_SRC'($urandom & $urandom);
            end
            step(rr, $urandom_range(0, 4) == 0);
        end
        step('0, 1'b0);

        // drain the scoreboard
        repeat (4) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
